// File: rtl/gpca_op_sequencer_pkg.sv
//==============================================================================
// Module  : gpca_pkg
// Purpose : Shared opcodes, FSM states and field widths for the gpca sequencer.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package gpca_pkg;

  localparam int P_W  = 9;
  localparam int A_W  = 18;
  localparam int BC_W = 19;

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_SQR  = 2'd1;
  localparam logic [1:0] OP_SQRT = 2'd2;
  localparam logic [1:0] OP_DIV  = 2'd3;

  // Square / square-root rows start from a fixed B/C seed instead of an operand.
  localparam logic [BC_W-1:0] B_ROOT_INIT = {2'b00, {17{1'b1}}};
  localparam logic [BC_W-1:0] C_ROOT_INIT = {2'b01, {17{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gpca_op_sequencer_if.sv
//==============================================================================
// Module  : gpca_op_sequencer_if
// Purpose : Request, array-drive and result signals of the gpca sequencer.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface gpca_op_sequencer_if
  import gpca_pkg::*;
();

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [8:0]      in_a;
  logic [8:0]      in_b;

  logic            X;
  logic [P_W-1:0]  P;
  logic [A_W-1:0]  A;
  logic [BC_W-1:0] B;
  logic [BC_W-1:0] C;
  logic [P_W-1:0]  F;
  logic [BC_W-1:0] S;

  logic            res_valid;
  logic            res_ready;
  logic [8:0]      res_f;
  logic [18:0]     res_s;
  logic [1:0]      res_op;
  logic            res_dz;

  modport slave (
    input  in_valid, in_op, in_a, in_b, F, S, res_ready,
    output in_ready, X, P, A, B, C, res_valid, res_f, res_s, res_op, res_dz
  );

  modport master (
    output in_valid, in_op, in_a, in_b, F, S, res_ready,
    input  in_ready, X, P, A, B, C, res_valid, res_f, res_s, res_op, res_dz
  );

endinterface

`default_nettype wire

// File: rtl/gpca_op_sequencer_operand_fmt.sv
//==============================================================================
// Module  : gpca_operand_fmt
// Purpose : Combinational opcode/operand to X/P/A/B/C array-field mapper.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module gpca_operand_fmt
  import gpca_pkg::*;
(
  input  wire logic [1:0]      op_i,
  input  wire logic [8:0]      a_i,
  input  wire logic [8:0]      b_i,
  output logic                 x_o,
  output logic [P_W-1:0]       p_o,
  output logic [A_W-1:0]       a_o,
  output logic [BC_W-1:0]      b_o,
  output logic [BC_W-1:0]      c_o,
  output logic                 dz_o
);

  always_comb begin
    x_o  = 1'b0;
    p_o  = '0;
    a_o  = '0;
    b_o  = '0;
    c_o  = '0;
    dz_o = 1'b0;
    case (op_i)
      OP_MUL: begin
        p_o = a_i;
        b_o = {b_i, 10'b0};
        c_o = {b_i, 10'b0};
      end
      OP_SQR: begin
        p_o = a_i;
        b_o = B_ROOT_INIT;
        c_o = C_ROOT_INIT;
      end
      OP_SQRT: begin
        x_o = 1'b1;
        a_o = {9'b0, a_i};
        b_o = B_ROOT_INIT;
        c_o = C_ROOT_INIT;
      end
      default: begin
        x_o  = 1'b1;
        a_o  = {a_i, 9'b0};
        b_o  = {b_i, 10'b0};
        c_o  = {b_i, 10'b0};
        dz_o = (b_i == 9'd0);
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/gpca_op_sequencer.sv
//==============================================================================
// Module  : gpca_op_sequencer
// Purpose : Registers array drive fields, waits LATENCY cycles, captures F/S.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module gpca_op_sequencer
  import gpca_pkg::*;
#(
  parameter int LATENCY = 9,
  parameter int CNT_W   = 8
) (
  input  wire logic            clk,
  input  wire logic            rst,
  gpca_op_sequencer_if.slave   bus_io
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              x_q, x_d;
  logic [P_W-1:0]    p_q, p_d;
  logic [A_W-1:0]    a_q, a_d;
  logic [BC_W-1:0]   b_q, b_d;
  logic [BC_W-1:0]   c_q, c_d;
  logic              res_valid_q, res_valid_d;
  logic [P_W-1:0]    res_f_q, res_f_d;
  logic [BC_W-1:0]   res_s_q, res_s_d;
  logic [1:0]        res_op_q, res_op_d;
  logic              res_dz_q, res_dz_d;

  logic              fmt_x;
  logic [P_W-1:0]    fmt_p;
  logic [A_W-1:0]    fmt_a;
  logic [BC_W-1:0]   fmt_b;
  logic [BC_W-1:0]   fmt_c;
  logic              fmt_dz;

  gpca_operand_fmt u_fmt (
    .op_i (bus_io.in_op),
    .a_i  (bus_io.in_a),
    .b_i  (bus_io.in_b),
    .x_o  (fmt_x),
    .p_o  (fmt_p),
    .a_o  (fmt_a),
    .b_o  (fmt_b),
    .c_o  (fmt_c),
    .dz_o (fmt_dz)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    x_d         = x_q;
    p_d         = p_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    res_valid_d = res_valid_q;
    res_f_d     = res_f_q;
    res_s_d     = res_s_q;
    res_op_d    = res_op_q;
    res_dz_d    = res_dz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.in_valid) begin
          op_d = bus_io.in_op;
          // Divide-by-zero is answered immediately; the array fields keep the previous op.
          if (fmt_dz) begin
            res_f_d     = '1;
            res_s_d     = '1;
            res_op_d    = bus_io.in_op;
            res_dz_d    = 1'b1;
            res_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end else begin
            x_d     = fmt_x;
            p_d     = fmt_p;
            a_d     = fmt_a;
            b_d     = fmt_b;
            c_d     = fmt_c;
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == '0) begin
          res_f_d     = bus_io.F;
          res_s_d     = bus_io.S;
          res_op_d    = op_q;
          res_dz_d    = 1'b0;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (bus_io.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      x_q         <= 1'b0;
      p_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      res_valid_q <= 1'b0;
      res_f_q     <= '0;
      res_s_q     <= '0;
      res_op_q    <= '0;
      res_dz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      x_q         <= x_d;
      p_q         <= p_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      res_valid_q <= res_valid_d;
      res_f_q     <= res_f_d;
      res_s_q     <= res_s_d;
      res_op_q    <= res_op_d;
      res_dz_q    <= res_dz_d;
    end
  end

  assign bus_io.in_ready  = (state_q == ST_IDLE);
  assign bus_io.X         = x_q;
  assign bus_io.P         = p_q;
  assign bus_io.A         = a_q;
  assign bus_io.B         = b_q;
  assign bus_io.C         = c_q;
  assign bus_io.res_valid = res_valid_q;
  assign bus_io.res_f     = res_f_q;
  assign bus_io.res_s     = res_s_q;
  assign bus_io.res_op    = res_op_q;
  assign bus_io.res_dz    = res_dz_q;

endmodule

`default_nettype wire
